exec_unit: RTL
==============

# exec_unit

Sequential 8-bit execute stage sitting between the operand read ports of the 8×8 register file and its write port. It captures the two register-file read values on `start`, computes an ALU or multi-cycle multiply result, and issues a single-cycle writeback (address, data, write strobe) that feeds the register file's write port directly. It also maintains zero/carry flags for the control sequencer.

## Interface
- `WIDTH`, 8, operand/result width; fixed at 8 for this MCU.
- `MUL_CYCLES`, 8, shift-add iterations for MUL; must equal `WIDTH`.

- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  launch operation; accepted only when `busy`=0.
- `opcode`  in  4  operation select (see Operation).
- `rd`  in  3  destination register index.
- `op_a`  in  8  operand A (register file port A).
- `op_b`  in  8  operand B (register file port B).
- `busy`  out  1  operation in flight; `start` ignored while high.
- `done`  out  1  one-cycle pulse at completion (including illegal ops).
- `illegal`  out  1  one-cycle pulse with `done` for an unsupported opcode.
- `wb_write`  out  1  register file write strobe, one cycle.
- `wb_addr`  out  3  register file write address.
- `wb_data`  out  8  register file write data.
- `flag_z`  out  1  result == 0, from the last completed legal op.
- `flag_c`  out  1  carry/borrow/overflow, from the last completed legal op.

## Operation
- Opcodes: 0 ADD (c = carry out), 1 SUB a−b (c = borrow, a<b), 2 AND, 3 OR, 4 XOR (logic: c=0), 5 SHL a<<1 (c = a[7]), 6 SHR a>>1 logical (c = a[0]), 7 MUL low byte of a×b (c = high byte ≠ 0), 8 PASSB (result = b, c=0), 9–15 illegal.
- All arithmetic modulo 256; ADD/SUB computed at 9 bits, bit 8 is the carry.
- States: IDLE → (start, single-cycle op) WB; IDLE → (start, MUL) MUL; MUL → (iteration count = MUL_CYCLES) WB; WB → IDLE. Illegal opcode: IDLE → WB with no write.
- On accepted `start`: `op_a`, `op_b`, `opcode`, `rd` registered; later input changes have no effect.
- MUL: 16-bit shift-add, one multiplier bit per cycle, LSB first; 4-bit iteration counter.
- WB state: `done`=1; `wb_write`=1 only if opcode legal and `rd`≠0; `wb_addr`=rd, `wb_data`=result; flags updated for every legal op (including rd=0). Illegal: `illegal`=1, `wb_write`=0, flags unchanged.
- `start` while `busy`=1: ignored, no queueing.

## Timing
- Reset values: `busy`, `done`, `illegal`, `wb_write`, `flag_z`, `flag_c` = 0; `wb_addr`=0; `wb_data`=0x00; state IDLE; counter 0.
- All outputs registered.
- Single-cycle op: `start` sampled at edge E0; `done`/`wb_write` high in cycle after E0; register file captures at E1. `busy` high that same cycle, low after.
- MUL: `start` at E0; `busy` high for 9 cycles (8 MUL + 1 WB); `done` in the 9th cycle after E0.
- Back-to-back: new `start` accepted at the edge that ends the WB cycle (`busy` low that cycle → accepted next cycle); max throughput 1 op / 2 cycles.
- Reset asserted mid-MUL or mid-WB: immediate return to reset values; no writeback occurs, partial product discarded.
- Outside WB: `wb_write`, `done`, `illegal` = 0; `wb_addr`/`wb_data` hold last value.

## Configuration
- `EXEC_MUL_EN` defined: MUL (opcode 7) implemented as above, MUL state present.
- `EXEC_MUL_EN` undefined: MUL state and multiplier datapath removed; opcode 7 treated as illegal (`done`+`illegal` one cycle after start, no write, flags unchanged).

## Test plan
- Reset: hold `rst_n`=0 with random inputs → all outputs 0; release, `start` with ADD 0x7F+0x01 rd=3 → next cycle `wb_write`=1, `wb_addr`=3, `wb_data`=0x80, z=0, c=0.
- Carry/borrow: ADD 0xFF+0x01 rd=2 → `wb_data`=0x00, z=1, c=1; SUB 0x10−0x20 → 0xF0, c=1; SHR 0x01 → 0x00, z=1, c=1.
- MUL (`EXEC_MUL_EN`): 0x12×0x34 rd=5 → `busy` 9 cycles, `wb_data`=0xA8, c=1; `start` pulsed mid-op is ignored.
- r0 and illegal: AND 0xF0&0x0F rd=0 → `done`=1, `wb_write`=0, z=1; opcode 12 → `illegal`=1, flags unchanged.
- Reset mid-MUL at cycle 4 → no `wb_write`, `busy`=0 immediately, next op executes normally.
- Without `EXEC_MUL_EN`: opcode 7 → `done`=`illegal`=1 one cycle after start, `wb_write`=0.

Source files
------------

// File: rtl/exec_if.sv
// Execute-stage bus: operand/launch inputs from the sequencer and register
// file, plus writeback and status outputs from the execute unit.
// The unit connects through the slave modport and its driver through master.
interface exec_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [3:0]       opcode;
  logic [2:0]       rd;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic             illegal;
  logic             wb_write;
  logic [2:0]       wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             flag_z;
  logic             flag_c;

  modport master (
    output start, opcode, rd, op_a, op_b,
    input  busy, done, illegal, wb_write, wb_addr, wb_data, flag_z, flag_c
  );

  modport slave (
    input  start, opcode, rd, op_a, op_b,
    output busy, done, illegal, wb_write, wb_addr, wb_data, flag_z, flag_c
  );
endinterface

// File: rtl/exec_unit.sv
// exec_unit: sequential 8-bit execute stage between register-file read ports
// and the register-file write port. Single-cycle ALU ops go IDLE -> WB;
// MUL runs an 8-step shift-add (IDLE -> MUL -> WB). All outputs registered.
// Optional feature macro: EXEC_MUL_EN (defined: opcode 7 is a multiply;
// undefined: multiplier removed and opcode 7 reports illegal).
module exec_unit #(
  parameter int WIDTH      = 8,
  parameter int MUL_CYCLES = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  exec_if.slave  bus
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SHL   = 4'd5;
  localparam logic [3:0] OP_SHR   = 4'd6;
  localparam logic [3:0] OP_PASSB = 4'd8;

  // The shift-add loop consumes one multiplier bit per step.
  if (MUL_CYCLES != WIDTH) begin : g_cfg_check
    $error("exec_unit: MUL_CYCLES must equal WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1
`ifdef EXEC_MUL_EN
    ,S_MUL = 2'd2
`endif
  } state_t;

  // Single-cycle ALU: returns {legal, carry, result}. MUL is not handled here.
  function automatic logic [WIDTH+1:0] alu(input logic [3:0] op,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   wide;
    logic             legal;
    logic             carry;
    logic [WIDTH-1:0] res;
    wide  = '0;
    legal = 1'b1;
    carry = 1'b0;
    res   = '0;
    case (op)
      OP_ADD:   begin wide = {1'b0, a} + {1'b0, b}; res = wide[WIDTH-1:0]; carry = wide[WIDTH]; end
      OP_SUB:   begin wide = {1'b0, a} - {1'b0, b}; res = wide[WIDTH-1:0]; carry = wide[WIDTH]; end
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_XOR:   res = a ^ b;
      OP_SHL:   begin res = {a[WIDTH-2:0], 1'b0}; carry = a[WIDTH-1]; end
      OP_SHR:   begin res = {1'b0, a[WIDTH-1:1]}; carry = a[0]; end
      OP_PASSB: res = b;
      default:  legal = 1'b0;
    endcase
    return {legal, carry, res};
  endfunction

  state_t           state_reg, state_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             illegal_reg, illegal_next;
  logic             wb_write_reg, wb_write_next;
  logic [2:0]       wb_addr_reg, wb_addr_next;
  logic [WIDTH-1:0] wb_data_reg, wb_data_next;
  logic             flag_z_reg, flag_z_next;
  logic             flag_c_reg, flag_c_next;
  logic [WIDTH+1:0] alu_out;

  assign alu_out = alu(bus.opcode, bus.op_a, bus.op_b);

`ifdef EXEC_MUL_EN
  localparam logic [3:0] OP_MUL   = 4'd7;
  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES);

  // acc holds {partial high half, remaining multiplier bits}; each step adds
  // the multiplicand into the high half when the current LSB is set, then
  // shifts the whole thing right by one.
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0]   a_reg, a_next;
  logic [2:0]         rd_reg, rd_next;
  logic [3:0]         cnt_reg, cnt_next;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_step;
  logic [3:0]         cnt_step;

  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, a_reg} : '0);
  assign acc_step = {mul_sum, acc_reg[WIDTH-1:1]};
  assign cnt_step = cnt_reg + 4'd1;
`endif

  // State and output registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      illegal_reg  <= 1'b0;
      wb_write_reg <= 1'b0;
      wb_addr_reg  <= '0;
      wb_data_reg  <= '0;
      flag_z_reg   <= 1'b0;
      flag_c_reg   <= 1'b0;
`ifdef EXEC_MUL_EN
      acc_reg      <= '0;
      a_reg        <= '0;
      rd_reg       <= '0;
      cnt_reg      <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      illegal_reg  <= illegal_next;
      wb_write_reg <= wb_write_next;
      wb_addr_reg  <= wb_addr_next;
      wb_data_reg  <= wb_data_next;
      flag_z_reg   <= flag_z_next;
      flag_c_reg   <= flag_c_next;
`ifdef EXEC_MUL_EN
      acc_reg      <= acc_next;
      a_reg        <= a_next;
      rd_reg       <= rd_next;
      cnt_reg      <= cnt_next;
`endif
    end
  end

  // Next-state and next-output decode; pulses default low, data/flags hold.
  always_comb begin
    state_next    = state_reg;
    busy_next     = 1'b0;
    done_next     = 1'b0;
    illegal_next  = 1'b0;
    wb_write_next = 1'b0;
    wb_addr_next  = wb_addr_reg;
    wb_data_next  = wb_data_reg;
    flag_z_next   = flag_z_reg;
    flag_c_next   = flag_c_reg;
`ifdef EXEC_MUL_EN
    acc_next      = acc_reg;
    a_next        = a_reg;
    rd_next       = rd_reg;
    cnt_next      = cnt_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
`ifdef EXEC_MUL_EN
          if (bus.opcode == OP_MUL) begin
            state_next = S_MUL;
            busy_next  = 1'b1;
            a_next     = bus.op_a;
            acc_next   = {{WIDTH{1'b0}}, bus.op_b};
            rd_next    = bus.rd;
            cnt_next   = 4'd0;
          end else
`endif
          begin
            // Single-cycle and illegal ops both complete in the next cycle.
            state_next = S_WB;
            busy_next  = 1'b1;
            done_next  = 1'b1;
            if (alu_out[WIDTH+1]) begin
              wb_addr_next  = bus.rd;
              wb_data_next  = alu_out[WIDTH-1:0];
              wb_write_next = (bus.rd != 3'd0);
              flag_z_next   = (alu_out[WIDTH-1:0] == '0);
              flag_c_next   = alu_out[WIDTH];
            end else begin
              illegal_next  = 1'b1;
            end
          end
        end
      end
`ifdef EXEC_MUL_EN
      S_MUL: begin
        busy_next = 1'b1;
        acc_next  = acc_step;
        cnt_next  = cnt_step;
        if (cnt_step == MUL_LAST) begin
          state_next    = S_WB;
          done_next     = 1'b1;
          wb_addr_next  = rd_reg;
          wb_data_next  = acc_step[WIDTH-1:0];
          wb_write_next = (rd_reg != 3'd0);
          flag_z_next   = (acc_step[WIDTH-1:0] == '0);
          flag_c_next   = (acc_step[2*WIDTH-1:WIDTH] != '0);
        end
      end
`endif
      S_WB: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.illegal  = illegal_reg;
  assign bus.wb_write = wb_write_reg;
  assign bus.wb_addr  = wb_addr_reg;
  assign bus.wb_data  = wb_data_reg;
  assign bus.flag_z   = flag_z_reg;
  assign bus.flag_c   = flag_c_reg;

endmodule
